sys_bus_rr: RTL and testbench

Parametrised successor to the system bus interconnect. Connects NrHosts bus hosts (core data port, debug module SBA, future DMA) to NrDevices memory-mapped devices using the existing req/gnt/rvalid protocol. Adds three things the current bus lacks: fair round-robin arbitration, decode-error responses for unmapped addresses, and a per-transaction response timeout. Sits in the system top in place of the current bus instance, with identical host/device port shapes.

---
 rtl/sys_bus_pkg.sv | 17 +
 rtl/sys_bus_rr_arbiter.sv | 32 +++
 rtl/sys_bus_rr.sv | 163 ++++++++++++++++
 tb/tb_sys_bus_rr.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Shared types and helpers for the round-robin system bus interconnect.
package sys_bus_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RSP = 2'd1,
      DEC_ERR  = 2'd2
   } sys_bus_state_e;

   // Index width for n items, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam logic [31:0] DecErrData = 32'h0000_0000;

endpackage

// File: rtl/sys_bus_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, wrapping modulo N.
module rr_arbiter #(
   parameter int N    = 2,
   parameter int IdxW = 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] last_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o
);

   int   cand_s;
   logic hit_s;
   logic found_s;

   // Scan last+1 .. last+N so the previous winner gets the lowest priority.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      found_s = 1'b0;
      cand_s  = 0;
      hit_s   = 1'b0;
      for (int k = 1; k <= N; k++) begin
         cand_s  = (int'(last_i) + k) % N;
         hit_s   = !found_s && req_i[IdxW'(cand_s)];
         gnt_o[IdxW'(cand_s)] = gnt_o[IdxW'(cand_s)] | hit_s;
         idx_o   = hit_s ? IdxW'(cand_s) : idx_o;
         found_s = found_s | hit_s;
      end
   end

endmodule

// File: rtl/sys_bus_rr.sv
// Single-outstanding host/device interconnect with round-robin arbitration,
// decode-error responses and a per-transaction response timeout.
module sys_bus_rr
   import sys_bus_pkg::*;
#(
   parameter int unsigned NrHosts       = 2,
   parameter int unsigned NrDevices     = 5,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned AddressWidth  = 32,
   parameter int unsigned TimeoutCycles = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NrHosts-1:0]        host_req_i,
   output logic [NrHosts-1:0]        host_gnt_o,
   input  logic [AddressWidth-1:0]   host_addr_i [NrHosts],
   input  logic [NrHosts-1:0]        host_we_i,
   input  logic [DataWidth/8-1:0]    host_be_i [NrHosts],
   input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
   output logic [NrHosts-1:0]        host_rvalid_o,
   output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
   output logic [NrHosts-1:0]        host_err_o,
   output logic [NrDevices-1:0]      device_req_o,
   output logic [AddressWidth-1:0]   device_addr_o [NrDevices],
   output logic [NrDevices-1:0]      device_we_o,
   output logic [DataWidth/8-1:0]    device_be_o [NrDevices],
   output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
   input  logic [NrDevices-1:0]      device_rvalid_i,
   input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
   input  logic [NrDevices-1:0]      device_err_i,
   input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
   input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices],
   output logic                      timeout_o
);

   localparam int HostIdxW = idx_width(int'(NrHosts));
   localparam int DevIdxW  = idx_width(int'(NrDevices));
   localparam int CntW     = idx_width(int'(TimeoutCycles) + 1);

   sys_bus_state_e          state_q, state_d;
   logic [HostIdxW-1:0]     last_grant_q, last_grant_d;
   logic [DevIdxW-1:0]      dev_idx_q, dev_idx_d;
   logic [CntW-1:0]         cnt_q, cnt_d;

   logic [NrHosts-1:0]      arb_gnt_s;
   logic [HostIdxW-1:0]     arb_idx_s;
   logic [NrDevices-1:0]    match_s;
   logic                    dec_hit_s;
   logic [DevIdxW-1:0]      dec_idx_s;

   rr_arbiter #(
      .N    (int'(NrHosts)),
      .IdxW (HostIdxW)
   ) u_arb (
      .req_i  (host_req_i),
      .last_i (last_grant_q),
      .gnt_o  (arb_gnt_s),
      .idx_o  (arb_idx_s)
   );

   // Address decode of the arbitration winner; lowest matching device wins.
   always_comb begin
      dec_idx_s = '0;
      for (int d = 0; d < int'(NrDevices); d++) begin
         match_s[d] = (host_addr_i[arb_idx_s] & cfg_device_addr_mask[d]) == cfg_device_addr_base[d];
      end
      for (int d = int'(NrDevices) - 1; d >= 0; d--) begin
         dec_idx_s = match_s[d] ? DevIdxW'(d) : dec_idx_s;
      end
      dec_hit_s = |match_s;
   end

   // Outputs are held at zero while rst_ni is low, even though grants are combinational.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      dev_idx_d    = dev_idx_q;
      cnt_d        = cnt_q;
      host_gnt_o   = '0;
      host_rvalid_o = '0;
      host_err_o   = '0;
      timeout_o    = 1'b0;
      device_req_o = '0;
      device_we_o  = '0;
      for (int h = 0; h < int'(NrHosts); h++) begin
         host_rdata_o[h] = '0;
      end
      for (int d = 0; d < int'(NrDevices); d++) begin
         device_addr_o[d]  = '0;
         device_be_o[d]    = '0;
         device_wdata_o[d] = '0;
      end
      if (!rst_ni) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (|host_req_i) begin
                  host_gnt_o   = arb_gnt_s;
                  last_grant_d = arb_idx_s;
                  if (dec_hit_s) begin
                     device_req_o[dec_idx_s]   = 1'b1;
                     device_addr_o[dec_idx_s]  = host_addr_i[arb_idx_s];
                     device_we_o[dec_idx_s]    = host_we_i[arb_idx_s];
                     device_be_o[dec_idx_s]    = host_be_i[arb_idx_s];
                     device_wdata_o[dec_idx_s] = host_wdata_i[arb_idx_s];
                     dev_idx_d = dec_idx_s;
                     cnt_d     = '0;
                     state_d   = WAIT_RSP;
                  end else begin
                     state_d = DEC_ERR;
                  end
               end else begin
                  state_d = IDLE;
               end
            end
            WAIT_RSP: begin
               if (device_rvalid_i[dev_idx_q]) begin
                  host_rvalid_o[last_grant_q] = 1'b1;
                  host_rdata_o[last_grant_q]  = device_rdata_i[dev_idx_q];
                  host_err_o[last_grant_q]    = device_err_i[dev_idx_q];
                  cnt_d   = '0;
                  state_d = IDLE;
               end else if (cnt_q == CntW'(TimeoutCycles)) begin
                  host_rvalid_o[last_grant_q] = 1'b1;
                  host_rdata_o[last_grant_q]  = DataWidth'(DecErrData);
                  host_err_o[last_grant_q]    = 1'b1;
                  timeout_o = 1'b1;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            DEC_ERR: begin
               host_rvalid_o[last_grant_q] = 1'b1;
               host_rdata_o[last_grant_q]  = DataWidth'(DecErrData);
               host_err_o[last_grant_q]    = 1'b1;
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State registers; last_grant resets to the top host so host 0 wins first.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         last_grant_q <= HostIdxW'(NrHosts - 1);
         dev_idx_q    <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         dev_idx_q    <= dev_idx_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_sys_bus_rr.sv
// Directed self-checking bench for sys_bus_rr: 2 hosts, 5 devices, 4-cycle timeout.
module tb_sys_bus_rr;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic [1:0]  host_req;
   logic [1:0]  host_gnt;
   logic [31:0] host_addr [2];
   logic [1:0]  host_we;
   logic [3:0]  host_be [2];
   logic [31:0] host_wdata [2];
   logic [1:0]  host_rvalid;
   logic [31:0] host_rdata [2];
   logic [1:0]  host_err;
   logic [4:0]  device_req;
   logic [31:0] device_addr [5];
   logic [4:0]  device_we;
   logic [3:0]  device_be [5];
   logic [31:0] device_wdata [5];
   logic [4:0]  device_rvalid;
   logic [31:0] device_rdata [5];
   logic [4:0]  device_err;
   logic [31:0] cfg_base [5];
   logic [31:0] cfg_mask [5];
   logic        timeout;

   logic [4:0]  resp_q = 5'b00000;
   logic [4:0]  inj_rvalid;
   int          checks = 0;
   int          failures = 0;
   logic [1:0]  exp_gnt [8];
   logic [1:0]  exp_rv  [8];

   always #5 clk = ~clk;

   sys_bus_rr #(
      .NrHosts       (2),
      .NrDevices     (5),
      .DataWidth     (32),
      .AddressWidth  (32),
      .TimeoutCycles (4)
   ) dut (
      .clk_i                (clk),
      .rst_ni               (rst_ni),
      .host_req_i           (host_req),
      .host_gnt_o           (host_gnt),
      .host_addr_i          (host_addr),
      .host_we_i            (host_we),
      .host_be_i            (host_be),
      .host_wdata_i         (host_wdata),
      .host_rvalid_o        (host_rvalid),
      .host_rdata_o         (host_rdata),
      .host_err_o           (host_err),
      .device_req_o         (device_req),
      .device_addr_o        (device_addr),
      .device_we_o          (device_we),
      .device_be_o          (device_be),
      .device_wdata_o       (device_wdata),
      .device_rvalid_i      (device_rvalid),
      .device_rdata_i       (device_rdata),
      .device_err_i         (device_err),
      .cfg_device_addr_base (cfg_base),
      .cfg_device_addr_mask (cfg_mask),
      .timeout_o            (timeout)
   );

   // Single-cycle responders on every device except device 3, which never answers.
   always @(posedge clk) begin
      for (int d = 0; d < 5; d++) begin
         resp_q[d] <= device_req[d] && (d != 3);
      end
   end
   assign device_rvalid = resp_q | inj_rvalid;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst_ni     = 1'b0;
      host_req   = 2'b00;
      host_we    = 2'b00;
      inj_rvalid = 5'b00000;
      for (int h = 0; h < 2; h++) begin
         host_addr[h]  = 32'h0000_0000;
         host_be[h]    = 4'hF;
         host_wdata[h] = 32'h0000_0000;
      end
      cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFFF_0000;
      cfg_base[1] = 32'h8000_1000; cfg_mask[1] = 32'hFFFF_F000;
      cfg_base[2] = 32'h8000_0000; cfg_mask[2] = 32'hFFFF_0000;
      cfg_base[3] = 32'h9000_0000; cfg_mask[3] = 32'hFFFF_0000;
      cfg_base[4] = 32'hA000_0000; cfg_mask[4] = 32'hFFFF_0000;
      device_rdata[0] = 32'hDEAD_BEEF;
      device_rdata[1] = 32'h1111_1111;
      device_rdata[2] = 32'h0000_6710;
      device_rdata[3] = 32'h3333_3333;
      device_rdata[4] = 32'h4444_4444;
      device_err      = 5'b01000;
      exp_gnt = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
      exp_rv  = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

      // Reset state
      next_cycle(); #1;
      check("rst_gnt", 32'(host_gnt), 32'h0);
      check("rst_rvalid", 32'(host_rvalid), 32'h0);
      check("rst_devreq", 32'(device_req), 32'h0);
      check("rst_timeout", 32'(timeout), 32'h0);
      next_cycle(); rst_ni = 1'b1;

      // Host 0 reads RAM
      next_cycle();
      host_req = 2'b01; host_addr[0] = 32'h0010_0010; host_we = 2'b00;
      #1;
      check("rd_gnt", 32'(host_gnt), 32'h1);
      check("rd_devreq", 32'(device_req), 32'h01);
      check("rd_devaddr", device_addr[0], 32'h0010_0010);
      next_cycle(); host_req = 2'b00; #1;
      check("rd_rvalid", 32'(host_rvalid), 32'h1);
      check("rd_rdata", host_rdata[0], 32'hDEAD_BEEF);
      check("rd_err", 32'(host_err), 32'h0);
      check("rd_devreq_once", 32'(device_req), 32'h0);
      next_cycle(); #1;
      check("rd_rdata_idle", host_rdata[0], 32'h0);

      // Both hosts hammer GPIO: grants alternate, one response cycle between grants
      host_req = 2'b11; host_addr[0] = 32'h8000_0000; host_addr[1] = 32'h8000_0000;
      for (int i = 0; i < 8; i++) begin
         if (i != 0) next_cycle();
         #1;
         check("rr_gnt", 32'(host_gnt), 32'(exp_gnt[i]));
         check("rr_rvalid", 32'(host_rvalid), 32'(exp_rv[i]));
         check("rr_rdata", host_rdata[0] | host_rdata[1], (exp_rv[i] != 2'b00) ? 32'h0000_6710 : 32'h0);
      end

      // Host 1 writes to an unmapped address
      next_cycle();
      host_req = 2'b10; host_we = 2'b10; host_addr[1] = 32'h4000_0000; host_wdata[1] = 32'h0BAD_F00D;
      #1;
      check("dec_gnt", 32'(host_gnt), 32'h2);
      check("dec_devreq", 32'(device_req), 32'h0);
      next_cycle(); host_req = 2'b00; host_we = 2'b00; #1;
      check("dec_rvalid", 32'(host_rvalid), 32'h2);
      check("dec_err", 32'(host_err), 32'h2);
      check("dec_rdata", host_rdata[1], 32'h0);

      // Silent device 3 times out after 5 cycles
      next_cycle();
      host_req = 2'b01; host_addr[0] = 32'h9000_0000;
      #1;
      check("to_gnt", 32'(host_gnt), 32'h1);
      check("to_devreq", 32'(device_req), 32'h08);
      for (int i = 1; i <= 4; i++) begin
         next_cycle(); host_req = 2'b00; #1;
         check("to_wait_rvalid", 32'(host_rvalid), 32'h0);
         check("to_wait_pulse", 32'(timeout), 32'h0);
      end
      next_cycle(); #1;
      check("to_rvalid", 32'(host_rvalid), 32'h1);
      check("to_err", 32'(host_err), 32'h1);
      check("to_rdata", host_rdata[0], 32'h0);
      check("to_pulse", 32'(timeout), 32'h1);
      next_cycle(); inj_rvalid = 5'b01000; #1;
      check("late_rvalid", 32'(host_rvalid), 32'h0);
      check("late_pulse", 32'(timeout), 32'h0);
      next_cycle(); inj_rvalid = 5'b00000;

      // Overlapping decode windows: lowest device wins
      host_req = 2'b01; host_addr[0] = 32'h8000_1000;
      #1;
      check("ovl_devreq", 32'(device_req), 32'h02);
      next_cycle(); host_req = 2'b00; #1;
      check("ovl_rdata", host_rdata[0], 32'h1111_1111);

      // Reset abandons an in-flight transaction
      next_cycle();
      host_req = 2'b10; host_addr[1] = 32'h9000_0000;
      #1;
      check("rstw_gnt", 32'(host_gnt), 32'h2);
      next_cycle();
      rst_ni = 1'b0; host_req = 2'b11; host_addr[0] = 32'h0010_0010;
      #1;
      check("rstw_gnt_low", 32'(host_gnt), 32'h0);
      check("rstw_rvalid_low", 32'(host_rvalid), 32'h0);
      check("rstw_devreq_low", 32'(device_req), 32'h0);
      check("rstw_rdata_low", host_rdata[0] | host_rdata[1], 32'h0);
      next_cycle(); rst_ni = 1'b1; #1;
      check("rstw_first_gnt", 32'(host_gnt), 32'h1);
      check("rstw_first_devreq", 32'(device_req), 32'h01);
      next_cycle(); host_req = 2'b00; #1;
      check("rstw_rvalid", 32'(host_rvalid), 32'h1);
      check("rstw_rdata", host_rdata[0], 32'hDEAD_BEEF);
      for (int i = 0; i < 6; i++) begin
         next_cycle(); #1;
         check("rstw_no_spurious", 32'(host_rvalid), 32'h0);
         check("rstw_no_timeout", 32'(timeout), 32'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
